// File: rtl/select_starvation_guard.sv
// rtl/select_starvation_guard.sv - per-entry wait tracking that narrows picker requests to a starved victim
module select_starvation_guard #(
   parameter int ENTRY_NUM = 16,
   parameter int CNT_WIDTH = 4,
   parameter int THRESHOLD = 12,
   parameter int COOLDOWN  = 4
) (
   input  logic                         clk,
   input  logic                         rstN,
   input  logic                         flush,
   input  logic [ENTRY_NUM-1:0]         request,
   input  logic [ENTRY_NUM-1:0]         grant,
   input  logic [ENTRY_NUM-1:0]         allocate,
   input  logic [ENTRY_NUM-1:0]         releaseEntry,   // "release" is a reserved word
   output logic [ENTRY_NUM-1:0]         maskedRequest,
   output logic                         boostActive,
   output logic [$clog2(ENTRY_NUM)-1:0] boostPtr,
   output logic [15:0]                  starveEvents
);
   localparam int PTR_W = $clog2(ENTRY_NUM);
   localparam int CW    = $clog2(COOLDOWN + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] THR     = CNT_WIDTH'(THRESHOLD);

   typedef enum logic [1:0] {ST_IDLE, ST_BOOST, ST_COOL} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q [ENTRY_NUM];
   logic [CNT_WIDTH-1:0] cnt_d [ENTRY_NUM];
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]        cool_q, cool_d;
   logic [15:0]          events_q, events_d;
   logic [ENTRY_NUM-1:0] starving;
   logic [PTR_W-1:0]     victim;

   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         cnt_d[i] = cnt_q[i];
         if (flush || allocate[i] || releaseEntry[i] || grant[i])
            cnt_d[i] = '0;
         else if (request[i] && cnt_q[i] != CNT_MAX)
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
   end

   // Descending scan so the lowest starving index is the one left in victim.
   always_comb begin
      starving = '0;
      victim   = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (cnt_q[i] >= THR) begin
            starving[i] = 1'b1;
            victim      = PTR_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cool_d   = cool_q;
      events_d = events_q;
      if (flush) begin
         state_d = ST_IDLE;
         cool_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|starving) begin
                  state_d = ST_BOOST;
                  ptr_d   = victim;
                  if (events_q != 16'hFFFF) events_d = events_q + 16'd1;
               end
            end
            ST_BOOST: begin
               if (grant[ptr_q]) begin
                  state_d = ST_COOL;
                  cool_d  = CW'(COOLDOWN - 1);
               end else if (releaseEntry[ptr_q] || allocate[ptr_q]) begin
                  state_d = ST_IDLE;
               end
            end
            ST_COOL: begin
               if (cool_q == '0) state_d = ST_IDLE;
               else              cool_d  = cool_q - CW'(1);
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         cool_q   <= '0;
         events_q <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cool_q   <= cool_d;
         events_q <= events_d;
         for (int i = 0; i < ENTRY_NUM; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // A victim waiting on operands does not block other ready entries.
   always_comb begin
      maskedRequest = request;
      if (state_q == ST_BOOST && request[ptr_q]) begin
         maskedRequest         = '0;
         maskedRequest[ptr_q]  = 1'b1;
      end
   end

   assign boostActive  = (state_q == ST_BOOST);
   assign boostPtr     = ptr_q;
   assign starveEvents = events_q;

   a_subset: assert property (@(posedge clk) disable iff (!rstN)
      (maskedRequest & ~request) == '0);

endmodule

// File: tb/tb_select_starvation_guard.sv
// tb/tb_select_starvation_guard.sv - self-checking bench for select_starvation_guard
module tb_select_starvation_guard;
   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] request = '0, grant = '0, allocate = '0, releaseEntry = '0;
   logic [15:0] maskedRequest;
   logic        boostActive;
   logic [3:0]  boostPtr;
   logic [15:0] starveEvents;

   int checks = 0;
   int errors = 0;

   int m_cnt [16];
   int m_state;   // 0 idle, 1 boost, 2 cool
   int m_ptr;
   int m_cool;
   int m_events;

   select_starvation_guard #(.ENTRY_NUM(16), .CNT_WIDTH(4), .THRESHOLD(12), .COOLDOWN(4)) dut (
      .clk(clk), .rstN(rstN), .flush(flush), .request(request), .grant(grant),
      .allocate(allocate), .releaseEntry(releaseEntry), .maskedRequest(maskedRequest),
      .boostActive(boostActive), .boostPtr(boostPtr), .starveEvents(starveEvents)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   task automatic model_reset();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_state = 0; m_ptr = 0; m_cool = 0; m_events = 0;
   endtask

   function automatic logic [15:0] model_mask(input logic [15:0] r);
      logic [15:0] one;
      one = 16'd1;
      if (m_state == 1 && r[m_ptr]) return one << m_ptr;
      return r;
   endfunction

   function automatic logic [15:0] pick_lowest(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return 16'd1 << i;
      return 16'd0;
   endfunction

   function automatic logic [15:0] pick_highest(input logic [15:0] v);
      for (int i = 15; i >= 0; i--) if (v[i]) return 16'd1 << i;
      return 16'd0;
   endfunction

   task automatic model_step(input logic [15:0] r, g, a, rl, input logic f);
      int victim;
      victim = -1;
      for (int i = 0; i < 16; i++) if (m_cnt[i] >= 12 && victim < 0) victim = i;
      if (f) begin
         m_state = 0; m_cool = 0;
      end else if (m_state == 0) begin
         if (victim >= 0) begin
            m_state = 1; m_ptr = victim;
            m_events = (m_events < 65535) ? m_events + 1 : 65535;
         end
      end else if (m_state == 1) begin
         if (g[m_ptr]) begin m_state = 2; m_cool = 3; end
         else if (rl[m_ptr] || a[m_ptr]) m_state = 0;
      end else begin
         if (m_cool == 0) m_state = 0;
         else m_cool = m_cool - 1;
      end
      for (int i = 0; i < 16; i++) begin
         if (f || a[i] || rl[i] || g[i]) m_cnt[i] = 0;
         else if (r[i]) m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
      end
   endtask

   task automatic drive(input logic [15:0] r, g, a, rl, input logic f);
      request = r; grant = g; allocate = a; releaseEntry = rl; flush = f;
      #1;
   endtask

   task automatic tick();
      model_step(request, grant, allocate, releaseEntry, flush);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstN = 1'b0;
      drive('0, '0, '0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      drive(16'h5A5A, '0, '0, '0, 1'b0);
      checks++;
      if (maskedRequest !== 16'h5A5A || boostActive !== 1'b0 || starveEvents !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got mask=%h boost=%b ev=%0d expected mask=5a5a boost=0 ev=0",
                  maskedRequest, boostActive, starveEvents);
      end
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      for (int c = 0; c < 20; c++) begin
         drive(16'h0003, pick_lowest(model_mask(16'h0003)), '0, '0, 1'b0);
         checks++;
         if (maskedRequest !== model_mask(16'h0003) || boostActive !== (m_state == 1)) begin
            errors++;
            $display("FAIL basic_cycle%0d: got mask=%h boost=%b expected mask=%h boost=%b",
                     c, maskedRequest, boostActive, model_mask(16'h0003), m_state == 1);
         end
         if (c == 12 || c == 14) begin
            checks++;
            if (boostActive !== 1'b0) begin
               errors++;
               $display("FAIL basic_idle_c%0d: got boost=%b expected 0", c, boostActive);
            end
         end
         if (c == 13) begin
            checks++;
            if (boostActive !== 1'b1 || boostPtr !== 4'd1 || maskedRequest !== 16'h0002) begin
               errors++;
               $display("FAIL basic_boost: got boost=%b ptr=%0d mask=%h expected 1 1 0002",
                        boostActive, boostPtr, maskedRequest);
            end
         end
         tick();
      end
      drive('0, '0, '0, '0, 1'b0);
      checks++;
      if (starveEvents !== 16'd1) begin
         errors++;
         $display("FAIL basic_events: got %0d expected 1", starveEvents);
      end
   endtask

   task automatic test_pass_through();
      do_reset();
      for (int c = 0; c < 13; c++) begin
         drive(16'h0021, pick_lowest(model_mask(16'h0021)), '0, '0, 1'b0);
         tick();
      end
      drive(16'h00C0, '0, '0, '0, 1'b0);
      checks++;
      if (boostActive !== 1'b1 || boostPtr !== 4'd5 || maskedRequest !== 16'h00C0) begin
         errors++;
         $display("FAIL pass_through: got boost=%b ptr=%0d mask=%h expected 1 5 00c0",
                  boostActive, boostPtr, maskedRequest);
      end
      tick();
      drive(16'h00C0, 16'h0040, '0, '0, 1'b0);
      tick();
      drive(16'h0060, pick_lowest(model_mask(16'h0060)), '0, '0, 1'b0);
      checks++;
      if (boostActive !== 1'b1 || maskedRequest !== 16'h0020) begin
         errors++;
         $display("FAIL victim_return: got boost=%b mask=%h expected 1 0020", boostActive, maskedRequest);
      end
      tick();
      drive(16'h0060, '0, '0, '0, 1'b0);
      checks++;
      if (boostActive !== 1'b0 || maskedRequest !== 16'h0060) begin
         errors++;
         $display("FAIL after_victim_grant: got boost=%b mask=%h expected 0 0060", boostActive, maskedRequest);
      end
   endtask

   task automatic test_two_victims();
      do_reset();
      for (int c = 0; c < 22; c++) begin
         drive(16'h0205, pick_lowest(model_mask(16'h0205)), '0, '0, 1'b0);
         if (c == 13 || c == 18 || c == 19) begin
            checks++;
            if (boostActive !== (c != 18) || (c != 18 && boostPtr !== ((c == 13) ? 4'd2 : 4'd9))) begin
               errors++;
               $display("FAIL two_victims_c%0d: got boost=%b ptr=%0d expected boost=%b ptr=%0d",
                        c, boostActive, boostPtr, c != 18, (c == 13) ? 2 : 9);
            end
         end
         tick();
      end
      drive('0, '0, '0, '0, 1'b0);
      checks++;
      if (starveEvents !== 16'd2) begin
         errors++;
         $display("FAIL two_victims_events: got %0d expected 2", starveEvents);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int c = 0; c < 13; c++) begin
         drive(16'h0003, pick_lowest(model_mask(16'h0003)), '0, '0, 1'b0);
         tick();
      end
      drive(16'h0003, 16'h0002, '0, '0, 1'b1);
      tick();
      for (int k = 0; k < 14; k++) begin
         drive(16'h0003, pick_lowest(model_mask(16'h0003)), '0, '0, 1'b0);
         checks++;
         if (boostActive !== (k == 13) || starveEvents !== ((k == 13) ? 16'd2 : 16'd1)) begin
            errors++;
            $display("FAIL flush_boost_k%0d: got boost=%b ev=%0d expected boost=%b ev=%0d",
                     k, boostActive, starveEvents, k == 13, (k == 13) ? 2 : 1);
         end
         tick();
      end
      do_reset();
      for (int c = 0; c < 12; c++) begin
         drive(16'h0003, pick_lowest(model_mask(16'h0003)), '0, '0, 1'b0);
         tick();
      end
      drive(16'h0003, 16'h0001, '0, '0, 1'b1);
      tick();
      drive(16'h0003, '0, '0, '0, 1'b0);
      checks++;
      if (boostActive !== 1'b0 || starveEvents !== 16'd0) begin
         errors++;
         $display("FAIL flush_at_threshold: got boost=%b ev=%0d expected 0 0", boostActive, starveEvents);
      end
   endtask

   task automatic test_release();
      do_reset();
      for (int c = 0; c < 13; c++) begin
         drive(16'h0003, pick_lowest(model_mask(16'h0003)), '0, '0, 1'b0);
         tick();
      end
      drive(16'h0003, '0, '0, 16'h0002, 1'b0);
      tick();
      for (int k = 0; k < 14; k++) begin
         drive(16'h0003, pick_lowest(model_mask(16'h0003)), '0, '0, 1'b0);
         checks++;
         if (boostActive !== (k == 13) || (k < 13 && maskedRequest !== 16'h0003)) begin
            errors++;
            $display("FAIL release_k%0d: got boost=%b mask=%h expected boost=%b mask=0003",
                     k, boostActive, maskedRequest, k == 13);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int c = 0; c < 13; c++) begin
         drive(16'h0003, pick_lowest(model_mask(16'h0003)), '0, '0, 1'b0);
         tick();
      end
      drive(16'h0003, '0, '0, '0, 1'b0);
      checks++;
      if (boostActive !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: got boost=%b expected 1", boostActive);
      end
      #1 rstN = 1'b0;
      #1;
      checks++;
      if (boostActive !== 1'b0 || maskedRequest !== 16'h0003 || starveEvents !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: got boost=%b mask=%h ev=%0d expected 0 0003 0",
                  boostActive, maskedRequest, starveEvents);
      end
      @(negedge clk);
      rstN = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      logic [15:0] base, r, g, a, rl, exp_mask;
      logic        f;
      int          mode;
      do_reset();
      base = 16'($urandom);
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 49) == 0) base = 16'($urandom);
         r = base | (16'($urandom) & 16'($urandom) & 16'($urandom));
         if ($urandom_range(0, 7) == 0) r = r & 16'($urandom);
         exp_mask = model_mask(r);
         mode = $urandom_range(0, 9);
         g = (mode < 7) ? pick_lowest(exp_mask) : (mode < 9) ? 16'd0 : pick_highest(exp_mask);
         a  = ($urandom_range(0, 15) == 0) ? 16'd1 << $urandom_range(0, 15) : 16'd0;
         rl = ($urandom_range(0, 15) == 0) ? 16'd1 << $urandom_range(0, 15) : 16'd0;
         f  = ($urandom_range(0, 79) == 0);
         drive(r, g, a, rl, f);
         checks++;
         if (maskedRequest !== exp_mask || (maskedRequest & ~r) !== 16'd0) begin
            errors++;
            $display("FAIL rand_mask_c%0d: got %h expected %h (req %h)", c, maskedRequest, exp_mask, r);
         end
         checks++;
         if (boostActive !== (m_state == 1) || starveEvents !== 16'(m_events)) begin
            errors++;
            $display("FAIL rand_state_c%0d: got boost=%b ev=%0d expected boost=%b ev=%0d",
                     c, boostActive, starveEvents, m_state == 1, m_events);
         end
         if (m_state == 1) begin
            checks++;
            if (boostPtr !== 4'(m_ptr)) begin
               errors++;
               $display("FAIL rand_ptr_c%0d: got %0d expected %0d", c, boostPtr, m_ptr);
            end
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_basic();
      test_pass_through();
      test_two_victims();
      test_flush();
      test_release();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
